// File: rtl/usb_ep_rx_data_framer_if.sv
// Receive-side byte stream plus endpoint fill port, bundled for the RX data framer.
`timescale 1ns/1ps
interface usb_ep_rx_data_framer_if;
    // packet receiver stream
    logic       rxStart_i;
    logic       rxValid_i;
    logic [7:0] rxData_i;
    logic       rxEop_i;
    logic       rxError_i;
    // endpoint fill port
    logic       epFull_i;
    logic       epByteIsData_o;
    logic       epDataValid_o;
    logic [7:0] epData_o;
    logic       epFillTransDone_o;
    logic       epFillTransSuccess_o;

    // framer side
    modport slave (
        input  rxStart_i, rxValid_i, rxData_i, rxEop_i, rxError_i, epFull_i,
        output epByteIsData_o, epDataValid_o, epData_o,
        output epFillTransDone_o, epFillTransSuccess_o
    );

    // receiver/endpoint side
    modport master (
        output rxStart_i, rxValid_i, rxData_i, rxEop_i, rxError_i, epFull_i,
        input  epByteIsData_o, epDataValid_o, epData_o,
        input  epFillTransDone_o, epFillTransSuccess_o
    );
endinterface

// File: rtl/usb_ep_rx_data_framer.sv
// Turns one received DATAx packet into endpoint fill writes: forwards the PID,
// strips the trailing CRC16 through a 2-byte delay line, checks CRC and length,
// and issues one commit/rollback decision per packet.
`timescale 1ns/1ps
module usb_ep_rx_data_framer #(
    parameter int MAX_PACKET_SIZE = 64,
    parameter int LEN_WID         = 11
) (
    input  logic                   clk12_i,
    input  logic                   rst_n_i,
    usb_ep_rx_data_framer_if.slave bus,
    output logic [LEN_WID-1:0]     packetLen_o,
    output logic                   crcErr_o
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PID  = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] DROP = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [LEN_WID-1:0] LEN_MAX      = LEN_WID'(MAX_PACKET_SIZE);
    localparam logic [LEN_WID-1:0] LEN_SAT      = LEN_WID'(MAX_PACKET_SIZE + 1);
    localparam logic [15:0]        CRC_INIT     = 16'hFFFF;
    localparam logic [15:0]        CRC_RESIDUAL = 16'h800D;

    logic [2:0]         state;
    logic [7:0]         dly0;      // oldest byte held back
    logic [7:0]         dly1;      // newest byte held back
    logic [1:0]         dlyCnt;    // bytes held, saturates at 2
    logic [15:0]        crc;
    logic [LEN_WID-1:0] lenCnt;
    logic               overflow;

    logic               pidOk;
    logic               emit;
    logic [15:0]        crcNext;
    logic [LEN_WID-1:0] lenNext;
    logic               ovfNext;
    logic [1:0]         cntNext;
    logic               inPacket;

    // Bit-serial USB CRC16 over one byte, LSB first.
    function automatic logic [15:0] crc16Byte(input logic [15:0] crcIn, input logic [7:0] data);
        logic [15:0] c;
        logic        fb;
        c = crcIn;
        for (int i = 0; i < 8; i++) begin
            fb = data[i] ^ c[15];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return c;
    endfunction

    // Next-value datapath for the payload byte arriving this cycle.
    always_comb begin
        // NOTE: every signal gets a value on every path here, so no latch is inferred.
        pidOk    = (bus.rxData_i[3:0] == ~bus.rxData_i[7:4]) && (bus.rxData_i[2:0] == 3'b011);
        inPacket = (state == PID) || (state == DATA) || (state == DROP);
        emit     = (state == DATA) && bus.rxValid_i && (dlyCnt == 2'd2);
        crcNext  = crc;
        cntNext  = dlyCnt;
        lenNext  = lenCnt;
        if ((state == DATA) && bus.rxValid_i) begin
            crcNext = crc16Byte(crc, bus.rxData_i);
            if (dlyCnt != 2'd2) begin
                cntNext = dlyCnt + 2'd1;
            end
        end
        if (emit && (lenCnt != LEN_SAT)) begin
            lenNext = lenCnt + LEN_WID'(1);
        end
        // Full is judged when a byte is committed to the output register.
        ovfNext = overflow || (emit && (bus.epFull_i || (lenNext > LEN_MAX)));
    end

    // Packet FSM, delay line, checks and registered endpoint outputs.
    always_ff @(posedge clk12_i) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
        if (!rst_n_i) begin
            // NOTE: the two delay bytes are cleared with the rest; they are flops, not RAM.
            state                    <= IDLE;
            dly0                     <= '0;
            dly1                     <= '0;
            dlyCnt                   <= '0;
            crc                      <= CRC_INIT;
            lenCnt                   <= '0;
            overflow                 <= 1'b0;
            bus.epByteIsData_o       <= 1'b0;
            bus.epDataValid_o        <= 1'b0;
            bus.epData_o             <= '0;
            bus.epFillTransDone_o    <= 1'b0;
            bus.epFillTransSuccess_o <= 1'b0;
            packetLen_o              <= '0;
            crcErr_o                 <= 1'b0;
        end else begin
            bus.epDataValid_o        <= 1'b0;
            bus.epFillTransDone_o    <= 1'b0;
            bus.epFillTransSuccess_o <= 1'b0;
            if (bus.rxStart_i) begin
                // A start inside a packet rolls back the old one; a finished packet needs nothing.
                if (inPacket) begin
                    bus.epFillTransDone_o <= 1'b1;
                end
                state    <= PID;
                dlyCnt   <= '0;
                crc      <= CRC_INIT;
                lenCnt   <= '0;
                overflow <= 1'b0;
            end else if (bus.rxError_i && inPacket) begin
                bus.epFillTransDone_o <= 1'b1;
                state                 <= IDLE;
                dlyCnt                <= '0;
            end else begin
                case (state)
                    PID: begin
                        if (bus.rxValid_i) begin
                            bus.epData_o       <= bus.rxData_i;
                            bus.epByteIsData_o <= 1'b0;
                        end
                        if (bus.rxEop_i) begin
                            bus.epFillTransDone_o <= 1'b1;
                            packetLen_o           <= '0;
                            crcErr_o              <= 1'b0;
                            state                 <= DONE;
                        end else if (bus.rxValid_i) begin
                            state <= pidOk ? DATA : DROP;
                        end
                    end
                    DATA: begin
                        if (bus.rxValid_i) begin
                            dly1 <= bus.rxData_i;
                            dly0 <= dly1;
                        end
                        if (emit) begin
                            bus.epData_o       <= dly0;
                            bus.epByteIsData_o <= 1'b1;
                            bus.epDataValid_o  <= 1'b1;
                        end
                        crc      <= crcNext;
                        dlyCnt   <= cntNext;
                        lenCnt   <= lenNext;
                        overflow <= ovfNext;
                        if (bus.rxEop_i) begin
                            bus.epFillTransDone_o    <= 1'b1;
                            bus.epFillTransSuccess_o <= (crcNext == CRC_RESIDUAL) &&
                                                        (cntNext == 2'd2) && !ovfNext;
                            packetLen_o              <= lenNext;
                            crcErr_o                 <= (crcNext != CRC_RESIDUAL);
                            state                    <= DONE;
                        end
                    end
                    DROP: begin
                        if (bus.rxEop_i) begin
                            bus.epFillTransDone_o <= 1'b1;
                            packetLen_o           <= '0;
                            crcErr_o              <= 1'b0;
                            state                 <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_ep_rx_data_framer.sv
// Scoreboard bench for usb_ep_rx_data_framer: expected endpoint writes and
// done decisions are queued as packets are driven and compared as they appear.
`timescale 1ns/1ps
module tb_usb_ep_rx_data_framer;

    localparam int MAX = 4;

    typedef logic [7:0] byte_q [$];
    typedef struct {
        logic        ok;
        logic        chk;
        logic [10:0] len;
        logic        crcErr;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] packetLen;
    logic        crcErr;
    int          total = 0;
    int          bad   = 0;

    logic [7:0]  expWr[$];
    done_t       expDone[$];

    usb_ep_rx_data_framer_if bus();

    usb_ep_rx_data_framer #(
        .MAX_PACKET_SIZE(MAX),
        .LEN_WID        (11)
    ) dut (
        .clk12_i    (clk),
        .rst_n_i    (rst_n),
        .bus        (bus.slave),
        .packetLen_o(packetLen),
        .crcErr_o   (crcErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reflected-form CRC16 as transmitted on the wire: low byte first.
    function automatic logic [15:0] crcTx(input byte_q d);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (d[i]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ d[i][b]) c = (c >> 1) ^ 16'hA001;
                else                c = c >> 1;
            end
        end
        return ~c;
    endfunction

    // One receiver cycle; pulses drop again just after the sampling edge.
    task automatic drive(input logic start, input logic valid, input logic [7:0] data,
                         input logic eop, input logic err);
        bus.rxStart_i = start;
        bus.rxValid_i = valid;
        bus.rxData_i  = data;
        bus.rxEop_i   = eop;
        bus.rxError_i = err;
        @(posedge clk);
        #1;
        bus.rxStart_i = 1'b0;
        bus.rxValid_i = 1'b0;
        bus.rxEop_i   = 1'b0;
        bus.rxError_i = 1'b0;
    endtask

    // endKind: 0 EOP with last CRC byte, 1 EOP on its own cycle,
    // 2 rxError after payload, 3 left open for a new rxStart, 4 left open for reset.
    task automatic runPacket(input string tag, input logic [7:0] pid, input byte_q pay,
                             input bit flip, input int endKind, input int fullAt);
        byte_q       s;
        logic [15:0] c;
        bit          isData;
        int          n;
        done_t       d;
        s = pay;
        if (endKind <= 1) begin
            c = crcTx(pay);
            s.push_back(c[7:0] ^ (flip ? 8'h01 : 8'h00));
            s.push_back(c[15:8]);
        end
        n      = s.size();
        isData = (pid == 8'hC3) || (pid == 8'h4B);
        if (isData) begin
            for (int i = 0; i < n - 2; i++) expWr.push_back(s[i]);
        end
        if (endKind <= 1) begin
            d.ok     = isData && !flip && ((n - 2) <= MAX) && (fullAt < 0);
            d.chk    = isData;
            d.len    = 11'(((n - 2) > MAX) ? MAX + 1 : n - 2);
            d.crcErr = flip;
            expDone.push_back(d);
        end else if (endKind <= 3) begin
            d = '{ok: 1'b0, chk: 1'b0, len: '0, crcErr: 1'b0};
            expDone.push_back(d);
        end
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, pid, 1'b0, 1'b0);
        check({tag, "_pid"}, {22'd0, bus.epByteIsData_o, bus.epDataValid_o, bus.epData_o},
              {22'd0, 2'b00, pid});
        for (int i = 0; i < n; i++) begin
            bus.epFull_i = (fullAt >= 0) && (i >= fullAt) && (i < fullAt + 3);
            drive(1'b0, 1'b1, s[i], (endKind == 0) && (i == n - 1), 1'b0);
        end
        bus.epFull_i = 1'b0;
        if (endKind == 1) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        if (endKind == 2) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            check({tag, "_errDone"}, {bus.epFillTransDone_o, bus.epFillTransSuccess_o}, 2'b10);
        end
    endtask

    // Bounded wait for the scoreboard to empty.
    task automatic waitIdle(input string tag);
        for (int i = 0; i < 20 && (expWr.size() != 0 || expDone.size() != 0); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_drained"}, expWr.size() + expDone.size(), 0);
    endtask

    // Scoreboard side: compare every write and done pulse as it appears.
    logic [7:0] monByte;
    done_t      monDone;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.epDataValid_o) begin
                check("wr_expected", expWr.size() != 0, 1);
                if (expWr.size() != 0) begin
                    monByte = expWr.pop_front();
                    check("wr_data", {bus.epByteIsData_o, bus.epData_o}, {1'b1, monByte});
                end
            end
            if (bus.epFillTransDone_o) begin
                check("done_expected", expDone.size() != 0, 1);
                if (expDone.size() != 0) begin
                    monDone = expDone.pop_front();
                    if (monDone.chk)
                        check("done_result", {bus.epFillTransSuccess_o, crcErr, packetLen},
                              {monDone.ok, monDone.crcErr, monDone.len});
                    else
                        check("done_fail", bus.epFillTransSuccess_o, 1'b0);
                end
            end else if (bus.epFillTransSuccess_o) begin
                check("succ_nodone", bus.epFillTransSuccess_o, 1'b0);
            end
        end
    end

    function automatic logic [31:0] allOuts();
        return {9'd0, bus.epByteIsData_o, bus.epDataValid_o, bus.epData_o,
                bus.epFillTransDone_o, bus.epFillTransSuccess_o, crcErr, packetLen};
    endfunction

    initial begin
        byte_q q;
        done_t d;
        rst_n         = 1'b0;
        bus.rxStart_i = 1'b0;
        bus.rxValid_i = 1'b0;
        bus.rxData_i  = 8'h00;
        bus.rxEop_i   = 1'b0;
        bus.rxError_i = 1'b0;
        bus.epFull_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", allOuts(), 0);
        rst_n = 1'b1;

        // good DATA0, 3-byte payload
        q = {8'h01, 8'h02, 8'h03};
        runPacket("good3", 8'hC3, q, 1'b0, 0, -1);
        waitIdle("good3");

        // same packet with a CRC bit flipped
        runPacket("crcbad", 8'hC3, q, 1'b1, 0, -1);
        waitIdle("crcbad");

        // reset mid-packet: one write already out, then everything clears, no done
        runPacket("rst", 8'hC3, q, 1'b0, 4, -1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_outs", allOuts(), 0);
        rst_n = 1'b1;
        waitIdle("rst");

        // IN token and a PID with a broken check nibble are dropped
        q.delete();
        runPacket("intoken", 8'h69, q, 1'b0, 0, -1);
        waitIdle("intoken");
        runPacket("badnib", 8'hD3, q, 1'b0, 1, -1);
        waitIdle("badnib");

        // length boundary around MAX
        q = {8'h10, 8'h20, 8'h30, 8'h40};
        runPacket("len4", 8'h4B, q, 1'b0, 1, -1);
        waitIdle("len4");
        q = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        runPacket("len5", 8'hC3, q, 1'b0, 0, -1);
        waitIdle("len5");
        q = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        runPacket("len6sat", 8'hC3, q, 1'b0, 0, -1);
        waitIdle("len6sat");

        // endpoint full around payload byte 2
        q = {8'h5A, 8'hA5, 8'h3C};
        runPacket("full", 8'hC3, q, 1'b0, 0, 1);
        waitIdle("full");

        // line error after two payload bytes, then stray EOP/error in IDLE
        q = {8'h11, 8'h22};
        runPacket("rxerr", 8'hC3, q, 1'b0, 2, -1);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        waitIdle("rxerr");
        q = {8'h77, 8'h88};
        runPacket("posterr", 8'hC3, q, 1'b0, 0, -1);
        waitIdle("posterr");

        // back-to-back start: first packet rolled back, second commits
        q = {8'h01, 8'h02, 8'h03};
        runPacket("abort", 8'hC3, q, 1'b0, 3, -1);
        q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        runPacket("second", 8'h4B, q, 1'b0, 0, -1);
        waitIdle("second");

        // EOP while still waiting for the PID
        d = '{ok: 1'b0, chk: 1'b0, len: '0, crcErr: 1'b0};
        expDone.push_back(d);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        waitIdle("pideop");

        // zero-length DATA1
        q.delete();
        runPacket("zlp", 8'h4B, q, 1'b0, 0, -1);
        waitIdle("zlp");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
